// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per clock, signed/unsigned,
// with RISC-V M-extension results for divide-by-zero and signed overflow.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    // dvd_reg shifts dividend bits out at the top and quotient bits in at the bottom
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] partial_reg;
    logic [WIDTH-1:0] div_mag_reg;
    logic [WIDTH-1:0] orig_dvd_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div_zero_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] partial_next;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Partial remainder is kept one bit wider while comparing so the shifted-out
    // MSB still takes part in the subtraction.
    always_comb begin
        shifted      = {partial_reg, dvd_reg[WIDTH-1]};
        diff         = shifted - {1'b0, div_mag_reg};
        q_bit        = ~diff[WIDTH];
        partial_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    always_comb begin
        dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    // MIN / -1 needs no special case: |MIN| / 1 = MIN, and negating MIN gives MIN.
    always_comb begin
        quo_fix = neg_q_reg ? -dvd_reg : dvd_reg;
        rem_fix = neg_r_reg ? -partial_reg : partial_reg;
        if (div_zero_reg) begin
            quo_fix = '1;
            rem_fix = orig_dvd_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            dvd_reg       <= '0;
            partial_reg   <= '0;
            div_mag_reg   <= '0;
            orig_dvd_reg  <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            div_zero_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        dvd_reg      <= dividend_mag;
                        div_mag_reg  <= divisor_mag;
                        orig_dvd_reg <= dividend;
                        partial_reg  <= '0;
                        count_reg    <= '0;
                        neg_q_reg    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_reg    <= is_signed && dividend[WIDTH-1];
                        div_zero_reg <= (divisor == '0);
                        in_ready_reg <= 1'b0;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    partial_reg <= partial_next;
                    dvd_reg     <= {dvd_reg[WIDTH-2:0], q_bit};
                    count_reg   <= count_reg + CW'(1);
                    if (count_reg == CW'(WIDTH - 1)) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    quotient_reg  <= quo_fix;
                    remainder_reg <= rem_fix;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus randomized
// operands compared against an arithmetic reference model.
module tb_divider;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    int checks = 0;
    int errors = 0;

    divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, truncating toward zero, with the
    // divide-by-zero rule layered on top.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Runs one operation with out_ready held high; returns results, latency and
    // whether in_ready was ever seen high while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output bit rdy_bad);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom);
        lat       = 0;
        rdy_bad   = in_ready;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) rdy_bad = 1'b1;
        end
        q = quotient;
        r = remainder;
        if (out_valid) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b q=%h r=%h, want 1 0 0 0",
                     in_ready, out_valid, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] q, r, eq, er;
        int lat;
        bit rb;
        logic [31:0] ta [7] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'hFFFF_FFFB,
                                32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] tb [7] = '{32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};
        logic        ts [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] xq [7] = '{32'd14, 32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] xr [7] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'hFFFF_FFFB, 32'd0, 32'd0};
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], ts[i], q, r, lat, rb);
            eq = xq[i];
            er = xr[i];
            checks++;
            if (q !== eq || r !== er || lat != LAT || rb) begin
                errors++;
                $display("FAIL directed[%0d] %h/%h s=%b: q=%h r=%h lat=%0d rdy_bad=%b, want q=%h r=%h lat=%0d",
                         i, ta[i], tb[i], ts[i], q, r, lat, rb, eq, er, LAT);
            end else begin
                $display("directed[%0d] %h/%h s=%b -> q=%h r=%h lat=%0d", i, ta[i], tb[i], ts[i], q, r, lat);
            end
        end
    endtask

    task automatic test_random(input logic s, input int n);
        logic [31:0] a, b, q, r, eq, er;
        int lat;
        bit rb;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(0, 15));
                1: b = b >> $urandom_range(1, 31);
                2: a = (($urandom_range(0, 1)) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                default: ;
            endcase
            ref_div(a, b, s, eq, er);
            run_op(a, b, s, q, r, lat, rb);
            checks++;
            if (q !== eq || r !== er || lat != LAT || rb) begin
                errors++;
                $display("FAIL random s=%b %h/%h: q=%h r=%h lat=%0d rdy_bad=%b, want q=%h r=%h lat=%0d",
                         s, a, b, q, r, lat, rb, eq, er, LAT);
            end else begin
                $display("random s=%b %h/%h -> q=%h r=%h", s, a, b, q, r);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] q0, r0, q, r, eq, er;
        int lat;
        bit rb;
        @(negedge clk);
        dividend  = 32'd1234567;
        divisor   = 32'd89;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q0 = quotient;
        r0 = remainder;
        checks++;
        if (lat != LAT || q0 !== 32'd13871 || r0 !== 32'd48) begin
            errors++;
            $display("FAIL bp_result: q=%h r=%h lat=%0d, want q=%h r=%h lat=%0d",
                     q0, r0, lat, 32'd13871, 32'd48, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            dividend  = $urandom;
            divisor   = $urandom;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== q0 || remainder !== r0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b q=%h r=%h, want 1 0 %h %h",
                         i, out_valid, in_ready, quotient, remainder, q0, r0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== q0 || remainder !== r0) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b q=%h r=%h, want 0 1 %h %h",
                     out_valid, in_ready, quotient, remainder, q0, r0);
        end
        ref_div(32'hFFFF_FF00, 32'd3, 1'b1, eq, er);
        run_op(32'hFFFF_FF00, 32'd3, 1'b1, q, r, lat, rb);
        checks++;
        if (q !== eq || r !== er || lat != LAT || rb) begin
            errors++;
            $display("FAIL bp_next: q=%h r=%h lat=%0d, want q=%h r=%h lat=%0d", q, r, lat, eq, er, LAT);
        end else begin
            $display("backpressure held %h/%h, next op q=%h r=%h", q0, r0, q, r);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r;
        int lat;
        bit rb, seen;
        @(negedge clk);
        dividend  = 32'd999;
        divisor   = 32'd7;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b q=%h r=%h, want 0 1 0 0",
                     out_valid, in_ready, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_discard: out_valid=1 seen after reset, want 0");
        end
        run_op(32'd1000, 32'd10, 1'b0, q, r, lat, rb);
        checks++;
        if (q !== 32'd100 || r !== 32'd0 || lat != LAT || rb) begin
            errors++;
            $display("FAIL reset_after: q=%h r=%h lat=%0d, want q=%h r=0 lat=%0d", q, r, lat, 32'd100, LAT);
        end else begin
            $display("reset mid-CALC then 1000/10 -> q=%0d r=%0d lat=%0d", q, r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(1'b0, 15);
        test_random(1'b1, 15);
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
